// File: rtl/vec_addsub_if.sv
// Bundle between vec_addsub and its upstream FWFT FIFO and downstream reader.
// slave is the block's side, master the producer/consumer side.
interface vec_addsub_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 3,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic signed [WIDTH-1:0] x   [LANES-1:0];
    logic signed [WIDTH-1:0] y   [LANES-1:0];
    logic                    op;
    logic                    in_empty;
    logic                    in_rd_en;
    logic signed [WIDTH-1:0] out [LANES-1:0];
    logic [LANES-1:0]        out_ovf;
    logic                    out_empty;
    logic                    out_rd_en;
    logic [CW-1:0]           out_count;

    modport slave (
        input  x, y, op, in_empty, out_rd_en,
        output in_rd_en, out, out_ovf, out_empty, out_count
    );

    modport master (
        output x, y, op, in_empty, out_rd_en,
        input  in_rd_en, out, out_ovf, out_empty, out_count
    );
endinterface

// File: rtl/vec_addsub.sv
// Multi-lane signed add / reverse-subtract with overflow detection,
// one stage-1 register and a FWFT result buffer sized to never stall it.
module vec_addsub #(
    parameter int WIDTH    = 32,
    parameter int LANES    = 3,
    parameter int DEPTH    = 16,
    parameter int SATURATE = 0
) (
    input logic        clock,
    input logic        reset,
    vec_addsub_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0]   w_ext [LANES];
    logic signed [WIDTH-1:0] w_res [LANES];
    logic [LANES-1:0]        w_ovf;
    logic [CW:0]             w_occ;
    logic                    w_rd;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;

    logic                    r_s1_valid;
    logic signed [WIDTH-1:0] r_s1_res [LANES];
    logic [LANES-1:0]        r_s1_ovf;

    logic signed [WIDTH-1:0] r_mem     [DEPTH][LANES];
    logic [LANES-1:0]        r_mem_ovf [DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Sign-extended WIDTH+1 arithmetic; overflow when the top two bits differ.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (bus.op)
                w_ext[l] = {bus.y[l][WIDTH-1], bus.y[l]}
                         - {bus.x[l][WIDTH-1], bus.x[l]};
            else
                w_ext[l] = {bus.x[l][WIDTH-1], bus.x[l]}
                         + {bus.y[l][WIDTH-1], bus.y[l]};
            w_ovf[l] = w_ext[l][WIDTH] ^ w_ext[l][WIDTH-1];
            w_res[l] = w_ext[l][WIDTH-1:0];
            if (SATURATE != 0 && w_ovf[l])
                w_res[l] = w_ext[l][WIDTH] ? MINV : MAXV;
        end
    end

    // Stage 1 is counted as occupied so its write can never hit a full buffer.
    assign w_occ   = {1'b0, r_count} + (CW+1)'(r_s1_valid);
    assign w_rd    = !reset && !bus.in_empty && (w_occ < (CW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = r_s1_valid;
    assign w_pop   = bus.out_rd_en && !w_empty;

    assign bus.in_rd_en  = w_rd;
    assign bus.out_empty = w_empty;
    assign bus.out_count = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_s1_valid <= 1'b0;
        else
            r_s1_valid <= w_rd;
    end

    always_ff @(posedge clock) begin
        if (w_rd) begin
            r_s1_res <= w_res;
            r_s1_ovf <= w_ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr]     <= r_s1_res;
            r_mem_ovf[r_wr_ptr] <= r_s1_ovf;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= nxt(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= nxt(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        bus.out_ovf = w_empty ? '0 : r_mem_ovf[r_rd_ptr];
        for (int l = 0; l < LANES; l++)
            bus.out[l] = w_empty ? '0 : r_mem[r_rd_ptr][l];
    end
endmodule
